parity_generator: RTL and testbench
===================================

Name: parity_generator

Overview:
Registered single-bit parity generator and checker for a DATA_WIDTH-bit data word. It computes even or odd parity over data_in, selected by a build-time parameter. It also flags a mismatch against an incoming parity bit. It sits on data paths such as UART/link framing and memory words, wherever a parity bit must be appended or verified one clock after the data is presented.

Parameters:
DATA_WIDTH, 8, width of data_in in bits; legal range ≥1.
PARITY_TYPE, 0, 0 = even parity (total ones including the parity bit is even); 1 = odd parity (total ones including the parity bit is odd).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; outputs clear immediately while low.
en  input  1  sample enable; data_in and parity_in are sampled only on rising clk with en=1.
data_in  input  DATA_WIDTH  data word to protect or check.
parity_in  input  1  received parity bit accompanying data_in; used only for the check.
parity_out  output  1  registered generated parity bit for the last sampled word.
parity_err  output  1  registered flag; 1 when parity_in disagrees with the parity computed for the same word.
valid_out  output  1  1 for exactly one cycle after each enabled sample.

Behaviour:
- Parity function: p = XOR-reduction of all DATA_WIDTH bits of data_in, XOR PARITY_TYPE.
  - Even mode: p = 1 iff the word has an odd number of ones.
  - Odd mode: p = 1 iff the word has an even number of ones.
- Reset (rst=0, asynchronous): parity_out=0, parity_err=0, valid_out=0, in both parity modes. Reset is held while rst is low. The first sample is taken on the first rising clk with rst=1 and en=1.
- Latency: 1 clock. On a rising clk with rst=1 and en=1:
  - parity_out ← p
  - parity_err ← p XOR parity_in
  - valid_out ← 1
- On a rising clk with en=0: parity_out and parity_err hold their previous values; valid_out ← 0.
- Back-to-back: en held high samples every cycle, valid_out stays high, and each result corresponds to the word of the previous cycle. There are no bubbles and no backpressure.
- Reset mid-operation: asserting rst clears all three outputs asynchronously. Any sample in flight is discarded. No output glitches to stale data after rst is released.
- data_in or parity_in changing between clock edges has no effect. No combinational path exists from the inputs to the outputs.
- Width rules:
  - DATA_WIDTH=1: parity equals the data bit XOR PARITY_TYPE.
  - All-zeros word: p = PARITY_TYPE.
  - All-ones word: p = (DATA_WIDTH mod 2) XOR PARITY_TYPE.
- The X-free reduction must be synthesizable as a balanced XOR tree. No multicycle paths are required for DATA_WIDTH ≤ 64.

Test Plan:
- Reset: hold rst=0 with en=1 and data_in=8'hFF -> parity_out=0, parity_err=0, valid_out=0 throughout. Releasing rst then one enabled edge -> valid_out=1.
- Even mode (PARITY_TYPE=0, DATA_WIDTH=8), en=1:
  - data_in=8'hFF -> parity_out=0 one cycle later.
  - Then data_in=8'b01010100 (3 ones) -> parity_out=1 on the next cycle.
  - Then data_in=8'h00 -> 0.
- Odd mode (PARITY_TYPE=1):
  - data_in=8'hFF -> parity_out=1.
  - data_in=8'h54 -> parity_out=0.
  - data_in=8'h00 -> parity_out=1.
- Check path, even mode:
  - data_in=8'h54 with parity_in=1 -> parity_err=0.
  - Same word with parity_in=0 -> parity_err=1.
  - data_in=8'hFF with parity_in=1 -> parity_err=1.
- Enable: sample 8'h54 with en=1, then set en=0 and change data_in to 8'hFF for 3 cycles -> parity_out stays 1 and valid_out=0 on those cycles.
- Async reset mid-stream: stream alternating 8'h01/8'h03 with en=1, pulse rst low between edges -> outputs drop to 0 immediately without waiting for clk. After release, the first enabled edge gives the correct parity for the current word.

Source files
------------

// File: rtl/parity_generator.sv
// -----------------------------------------------------------------------------
// parity_generator
//
// Registered single-bit parity generator and checker. One clock after a word
// is sampled (en=1), parity_out carries the generated parity for that word and
// parity_err flags disagreement with the parity bit that accompanied it.
// PARITY_TYPE selects even (0) or odd (1) parity. The parity is defined so
// that the total number of ones, counting the parity bit, matches the mode.
//
// Ports:
//   clk        : system clock, rising-edge active
//   rst        : asynchronous, active-low reset; clears all outputs
//   en         : sample enable for data_in / parity_in
//   data_in    : DATA_WIDTH-bit word to protect or check
//   parity_in  : received parity bit for data_in (check path only)
//   parity_out : registered generated parity of the last sampled word
//   parity_err : registered mismatch flag (parity_in != generated parity)
//   valid_out  : high for one cycle after each enabled sample
// -----------------------------------------------------------------------------
module parity_generator #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_in,
  output logic                  parity_out,
  output logic                  parity_err,
  output logic                  valid_out
);

  localparam logic PTYPE = (PARITY_TYPE != 0);

  // XOR reduction maps onto a balanced XOR tree; depth is log2(DATA_WIDTH),
  // which comfortably closes in one cycle for widths up to 64.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ PTYPE;
  endfunction

  logic p_p0;
  logic parity_p1;
  logic err_p1;
  logic vld_p1;

  // Stage p0: combinational parity of the word being presented
  assign p_p0 = calc_parity(data_in);

  // Stage p1: registered results. The data registers are reset along with
  // the valid flag so that no stale parity is visible after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_p1 <= 1'b0;
      err_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= en;
      if (en) begin
        parity_p1 <= p_p0;
        err_p1    <= p_p0 ^ parity_in;
      end
    end
  end

  assign parity_out = parity_p1;
  assign parity_err = err_p1;
  assign valid_out  = vld_p1;

endmodule

// File: tb/tb_parity_generator.sv
// -----------------------------------------------------------------------------
// tb_parity_generator
//
// Drives three instances in parallel from shared stimulus: 8-bit even parity,
// 8-bit odd parity and 1-bit even parity. Expected outputs come from a ones-
// count reference model evaluated at every sampled edge.
// -----------------------------------------------------------------------------
module tb_parity_generator;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] data = 8'h00;
  logic       pin = 1'b0;
  logic [0:0] data1;

  logic po [N];
  logic pe [N];
  logic pv [N];

  logic exp_p   [N];
  logic exp_err [N];
  logic exp_v;

  int total  = 0;
  int passed = 0;

  // instance configuration: width, parity type
  int cfg_w [N] = '{8, 8, 1};
  int cfg_t [N] = '{0, 1, 0};

  assign data1 = data[0:0];

  always #5 clk = ~clk;

  parity_generator #(.DATA_WIDTH(8), .PARITY_TYPE(0)) u_even (
    .clk(clk), .rst(rst), .en(en), .data_in(data), .parity_in(pin),
    .parity_out(po[0]), .parity_err(pe[0]), .valid_out(pv[0]));

  parity_generator #(.DATA_WIDTH(8), .PARITY_TYPE(1)) u_odd (
    .clk(clk), .rst(rst), .en(en), .data_in(data), .parity_in(pin),
    .parity_out(po[1]), .parity_err(pe[1]), .valid_out(pv[1]));

  parity_generator #(.DATA_WIDTH(1), .PARITY_TYPE(0)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .data_in(data1), .parity_in(pin),
    .parity_out(po[2]), .parity_err(pe[2]), .valid_out(pv[2]));

  // Reference: parity bit makes the total ones count even (type 0) or odd (1).
  function automatic logic model_parity(input logic [7:0] d, input int w, input int t);
    int ones = 0;
    for (int i = 0; i < w; i++) ones += d[i];
    return logic'(((ones % 2) + t) % 2);
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, expv);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s[%0d].parity_out", tag, k), po[k], exp_p[k]);
      check($sformatf("%s[%0d].parity_err", tag, k), pe[k], exp_err[k]);
      check($sformatf("%s[%0d].valid_out", tag, k), pv[k], exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      exp_p[k]   = 1'b0;
      exp_err[k] = 1'b0;
    end
    exp_v = 1'b0;
  endtask

  // Present inputs at the falling edge, then check #1 after the rising edge.
  task automatic step(input string tag, input logic [7:0] d, input logic p, input logic e);
    @(negedge clk);
    data = d;
    pin  = p;
    en   = e;
    @(posedge clk);
    if (rst) begin
      if (e) begin
        for (int k = 0; k < N; k++) begin
          exp_p[k]   = model_parity(d, cfg_w[k], cfg_t[k]);
          exp_err[k] = exp_p[k] ^ p;
        end
      end
      exp_v = e;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();

    // Reset held low with enable active and an all-ones word
    rst = 1'b0;
    #1;
    check_all("reset_async");
    for (int i = 0; i < 3; i++) step("reset_hold", 8'hFF, 1'b1, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    step("first_sample", 8'hFF, 1'b0, 1'b1);

    // Directed parity patterns, back to back
    step("all_ones", 8'hFF, 1'b0, 1'b1);
    step("three_ones", 8'b0101_0100, 1'b0, 1'b1);
    step("all_zeros", 8'h00, 1'b0, 1'b1);

    // Check path
    step("chk_54_p1", 8'h54, 1'b1, 1'b1);
    step("chk_54_p0", 8'h54, 1'b0, 1'b1);
    step("chk_ff_p1", 8'hFF, 1'b1, 1'b1);
    step("chk_01_p1", 8'h01, 1'b1, 1'b1);

    // Enable low holds results and drops valid
    step("en_sample", 8'h54, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("en_hold", 8'hFF, 1'b1, 1'b0);
    step("en_resume", 8'hFF, 1'b1, 1'b1);

    // Async reset mid-stream
    for (int i = 0; i < 4; i++) step("stream", (i % 2) ? 8'h03 : 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    data = 8'h01;
    en   = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset_async");
    @(posedge clk);
    #1;
    check_all("mid_reset_edge");
    @(negedge clk);
    rst = 1'b1;
    step("post_reset", 8'h03, 1'b1, 1'b1);
    step("post_reset2", 8'h01, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] rd;
      logic       rp;
      logic       re;
      rd = 8'($urandom);
      rp = 1'($urandom);
      re = ($urandom_range(0, 3) != 0);
      step("random", rd, rp, re);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
